pipe_frontend_ctrl: RTL and testbench

- Consumes the stall, clear and redirect controls produced by the hazard/forwarding unit, and applies them to the PC, IF/ID and ID/EX pipeline registers.
- Owns the architectural fetch PC, the instruction valid bits, and bubble/NOP insertion.
- Its ID/EX outputs (rd, reg_wr, is_load, rs addresses) feed back to the hazard unit, which closes the loop.
- Sits between instruction memory, the ID decoder/branch comparator, and the EX stage.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_reg.sv | 22 ++
 rtl/pipe_frontend_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_frontend_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and the ID/EX control bundle for the pipeline front end.
package pipe_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_wr;
        logic       is_load;
        logic       valid;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: pipeline register with hold (priority) and synchronous clear to a bubble value.
module pipe_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_hold,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)        r_q <= RST_VAL;
        else if (!i_hold) r_q <= i_clear ? CLR_VAL : i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipe_frontend_ctrl.sv
// pipe_frontend_ctrl: fetch PC, IF/ID and ID/EX registers driven by hazard-unit stall/clear/redirect.
// Define PIPE_FRONTEND_PERF_EN to add saturating stall/flush/retire counters.
module pipe_frontend_ctrl
    import pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall_pc_if,
    input  logic            i_stall_if_id,
    input  logic            i_clear_if_id,
    input  logic            i_clear_id_ex,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic [XLEN-1:0] i_instr_if,
    input  logic [4:0]      i_rs1_addr_id,
    input  logic [4:0]      i_rs2_addr_id,
    input  logic [4:0]      i_rd_addr_id,
    input  logic            i_reg_wr_id,
    input  logic            i_is_load_id,
    output logic [XLEN-1:0] o_pc_if,
    output logic [XLEN-1:0] o_pc_id,
    output logic [XLEN-1:0] o_instr_id,
    output logic            o_valid_id,
    output logic [XLEN-1:0] o_pc_ex,
    output logic [4:0]      o_rs1_addr_ex,
    output logic [4:0]      o_rs2_addr_ex,
    output logic [4:0]      o_rd_addr_ex,
    output logic            o_reg_wr_ex,
    output logic            o_is_load_ex,
    output logic            o_valid_ex
`ifdef PIPE_FRONTEND_PERF_EN
    ,
    output logic [31:0]     o_stall_cycles,
    output logic [31:0]     o_flush_cnt,
    output logic [31:0]     o_retire_ex
`endif
);
    localparam int IFID_W = 2 * XLEN + 1;
    localparam int IDEX_W = XLEN + $bits(id_ex_ctrl_t);

    logic [XLEN-1:0]   r_pc;
    logic [IFID_W-1:0] w_ifid_d, w_ifid_q;
    logic [IDEX_W-1:0] w_idex_q;
    id_ex_ctrl_t       w_ctrl_id, w_ctrl_ex;

    // A redirect seen while the PC is stalled is dropped; the branch stays in ID and is re-issued.
    always_ff @(posedge i_clk) begin
        if (i_rst)               r_pc <= RESET_PC;
        else if (!i_stall_pc_if) r_pc <= i_branch_taken ? {i_branch_target[XLEN-1:1], 1'b0} : r_pc + XLEN'(4);
    end

    assign o_pc_if  = r_pc;
    assign w_ifid_d = i_clear_if_id ? {r_pc, XLEN'(NOP_INSTR), 1'b0} : {r_pc, i_instr_if, 1'b1};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL ({XLEN'(0), XLEN'(NOP_INSTR), 1'b0})
    ) u_if_id (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_hold  (i_stall_if_id),
        .i_clear (1'b0),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign {o_pc_id, o_instr_id, o_valid_id} = w_ifid_q;

    // Gating with valid keeps flushed NOPs from writing or raising load-use stalls.
    assign w_ctrl_id = '{rs1: i_rs1_addr_id, rs2: i_rs2_addr_id, rd: i_rd_addr_id,
                         reg_wr: i_reg_wr_id & o_valid_id, is_load: i_is_load_id & o_valid_id,
                         valid: o_valid_id};

    pipe_reg #(
        .W       (IDEX_W),
        .RST_VAL ({XLEN'(0), ID_EX_BUBBLE}),
        .CLR_VAL ({XLEN'(0), ID_EX_BUBBLE})
    ) u_id_ex (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_hold  (1'b0),
        .i_clear (i_clear_id_ex),
        .i_d     ({o_pc_id, w_ctrl_id}),
        .o_q     (w_idex_q)
    );

    assign {o_pc_ex, w_ctrl_ex} = w_idex_q;
    assign o_rs1_addr_ex = w_ctrl_ex.rs1;
    assign o_rs2_addr_ex = w_ctrl_ex.rs2;
    assign o_rd_addr_ex  = w_ctrl_ex.rd;
    assign o_reg_wr_ex   = w_ctrl_ex.reg_wr;
    assign o_is_load_ex  = w_ctrl_ex.is_load;
    assign o_valid_ex    = w_ctrl_ex.valid;

`ifdef PIPE_FRONTEND_PERF_EN
    logic [31:0] r_stall_cycles, r_flush_cnt, r_retire_ex;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_cnt    <= '0;
            r_retire_ex    <= '0;
        end else begin
            if (i_stall_pc_if && !(&r_stall_cycles))                 r_stall_cycles <= r_stall_cycles + 32'd1;
            if (i_clear_if_id && !i_stall_if_id && !(&r_flush_cnt)) r_flush_cnt    <= r_flush_cnt + 32'd1;
            if (o_valid_ex && !(&r_retire_ex))                       r_retire_ex    <= r_retire_ex + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cnt    = r_flush_cnt;
    assign o_retire_ex    = r_retire_ex;
`endif
endmodule

// File: tb/tb_pipe_frontend_ctrl.sv
// tb_pipe_frontend_ctrl: table-driven check of pipe_frontend_ctrl with RESET_PC=0x100 and imem returning the PC.
module tb_pipe_frontend_ctrl;
    logic        clk = 1'b0;
    logic        rst, stall_pc, stall_ifid, clr_ifid, clr_idex, br;
    logic [31:0] tgt;
    logic [31:0] pc_if, pc_id, instr_id, pc_ex;
    logic        valid_id, reg_wr_ex, is_load_ex, valid_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
`ifdef PIPE_FRONTEND_PERF_EN
    logic [31:0] stall_cycles, flush_cnt, retire_ex;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_frontend_ctrl #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall_pc_if   (stall_pc),
        .i_stall_if_id   (stall_ifid),
        .i_clear_if_id   (clr_ifid),
        .i_clear_id_ex   (clr_idex),
        .i_branch_taken  (br),
        .i_branch_target (tgt),
        .i_instr_if      (pc_if),
        .i_rs1_addr_id   (5'd1),
        .i_rs2_addr_id   (5'd2),
        .i_rd_addr_id    (5'd7),
        .i_reg_wr_id     (1'b1),
        .i_is_load_id    (1'b1),
        .o_pc_if         (pc_if),
        .o_pc_id         (pc_id),
        .o_instr_id      (instr_id),
        .o_valid_id      (valid_id),
        .o_pc_ex         (pc_ex),
        .o_rs1_addr_ex   (rs1_ex),
        .o_rs2_addr_ex   (rs2_ex),
        .o_rd_addr_ex    (rd_ex),
        .o_reg_wr_ex     (reg_wr_ex),
        .o_is_load_ex    (is_load_ex),
        .o_valid_ex      (valid_ex)
`ifdef PIPE_FRONTEND_PERF_EN
        ,
        .o_stall_cycles  (stall_cycles),
        .o_flush_cnt     (flush_cnt),
        .o_retire_ex     (retire_ex)
`endif
    );

    // ctl bits: {rst, stall_pc, stall_ifid, clr_ifid, clr_idex, br}
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] pc_if;
        logic [31:0] pc_id;
        logic [31:0] instr_id;
        logic        vid;
        logic [31:0] pc_ex;
        logic        vex;
        logic        rw;
        logic [4:0]  rd;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [31:0] t);
        {rst, stall_pc, stall_ifid, clr_ifid, clr_idex, br} = ctl;
        tgt = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{6'b100000, 32'h0,        32'h100,      32'h0,        32'h13,       1'b0, 32'h0,        1'b0, 1'b0, 5'd0};
        tbl[1]  = '{6'b000000, 32'h0,        32'h104,      32'h100,      32'h100,      1'b1, 32'h0,        1'b0, 1'b0, 5'd7};
        tbl[2]  = '{6'b000000, 32'h0,        32'h108,      32'h104,      32'h104,      1'b1, 32'h100,      1'b1, 1'b1, 5'd7};
        tbl[3]  = '{6'b011010, 32'h0,        32'h108,      32'h104,      32'h104,      1'b1, 32'h0,        1'b0, 1'b0, 5'd0};
        tbl[4]  = '{6'b000000, 32'h0,        32'h10C,      32'h108,      32'h108,      1'b1, 32'h104,      1'b1, 1'b1, 5'd7};
        tbl[5]  = '{6'b011011, 32'h200,      32'h10C,      32'h108,      32'h108,      1'b1, 32'h0,        1'b0, 1'b0, 5'd0};
        tbl[6]  = '{6'b000101, 32'h200,      32'h200,      32'h10C,      32'h13,       1'b0, 32'h108,      1'b1, 1'b1, 5'd7};
        tbl[7]  = '{6'b000000, 32'h0,        32'h204,      32'h200,      32'h200,      1'b1, 32'h10C,      1'b0, 1'b0, 5'd7};
        tbl[8]  = '{6'b000101, 32'h201,      32'h200,      32'h204,      32'h13,       1'b0, 32'h200,      1'b1, 1'b1, 5'd7};
        tbl[9]  = '{6'b000101, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h200,      32'h13,       1'b0, 32'h204,      1'b0, 1'b0, 5'd7};
        tbl[10] = '{6'b000000, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'h200,      1'b0, 1'b0, 5'd7};
        tbl[11] = '{6'b011100, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 5'd7};
        tbl[12] = '{6'b000110, 32'h0,        32'h4,        32'h0,        32'h13,       1'b0, 32'h0,        1'b0, 1'b0, 5'd0};
        tbl[13] = '{6'b111000, 32'h0,        32'h100,      32'h0,        32'h13,       1'b0, 32'h0,        1'b0, 1'b0, 5'd0};
        tbl[14] = '{6'b000000, 32'h0,        32'h104,      32'h100,      32'h100,      1'b1, 32'h0,        1'b0, 1'b0, 5'd7};

        drive(6'b100000, 32'h0);
        step();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ctl, tbl[i].tgt);
            step();
            chk("pc_if",    i, pc_if,              tbl[i].pc_if);
            chk("pc_id",    i, pc_id,              tbl[i].pc_id);
            chk("instr_id", i, instr_id,           tbl[i].instr_id);
            chk("valid_id", i, 32'(valid_id),      32'(tbl[i].vid));
            chk("pc_ex",    i, pc_ex,              tbl[i].pc_ex);
            chk("valid_ex", i, 32'(valid_ex),      32'(tbl[i].vex));
            chk("reg_wr_ex",i, 32'(reg_wr_ex),     32'(tbl[i].rw));
            chk("is_load_ex",i,32'(is_load_ex),    32'(tbl[i].rw));
            chk("rd_ex",    i, 32'(rd_ex),         32'(tbl[i].rd));
            chk("rs1_ex",   i, 32'(rs1_ex),        (tbl[i].rd == 5'd7) ? 32'd1 : 32'd0);
            chk("rs2_ex",   i, 32'(rs2_ex),        (tbl[i].rd == 5'd7) ? 32'd2 : 32'd0);
        end

        // Redirect held off by a multi-cycle stall, then taken once the stall drops.
        drive(6'b100000, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(6'b011011, 32'h300);
            step();
            chk("stall_br_pc", 20 + i, pc_if, 32'h100);
        end
        drive(6'b000101, 32'h300);
        step();
        chk("br_release_pc",    23, pc_if,         32'h300);
        chk("br_release_vid",   23, 32'(valid_id), 32'd0);
        chk("br_release_pc_id", 23, pc_id,         32'h100);

`ifdef PIPE_FRONTEND_PERF_EN
        drive(6'b100000, 32'h0);
        step();
        chk("perf_rst_stall", 30, stall_cycles, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(6'b010000, 32'h0);
            step();
        end
        chk("perf_stall5", 31, stall_cycles, 32'd5);
        drive(6'b011100, 32'h0);
        step();
        chk("perf_flush_stalled", 32, flush_cnt, 32'd0);
        drive(6'b000100, 32'h0);
        step();
        chk("perf_flush1", 33, flush_cnt, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
